// File: rtl/nexys_starship_pkg.sv
// Shared constants for the Nexys Starship controller: one-hot state codes,
// default game tuning and part indices.
package nexys_starship_pkg;

  localparam logic [2:0] INIT     = 3'b001;
  localparam logic [2:0] PLAY     = 3'b010;
  localparam logic [2:0] GAMEOVER = 3'b100;

  typedef enum logic [2:0] {
    ST_INIT     = INIT,
    ST_PLAY     = PLAY,
    ST_GAMEOVER = GAMEOVER
  } state_t;

  localparam int DEF_MAX_HEALTH    = 7;
  localparam int DEF_GRACE_TICKS   = 8;
  localparam int DEF_DAMAGE_PERIOD = 4;

  localparam int TOP    = 0;
  localparam int BOTTOM = 1;
  localparam int LEFT   = 2;
  localparam int RIGHT  = 3;

endpackage

// File: rtl/nexys_starship_game_ctrl_if.sv
// Game-controller signal bundle: master is the controller, slave is the
// surrounding board logic (button, timer, repair state machines).
interface nexys_starship_game_ctrl_if #(
  parameter int NUM_PARTS = 4,
  parameter int HEALTH_W  = 3,
  parameter int SCORE_W   = 8
);
  logic                 timer_clk;
  logic                 BtnC;
  logic [NUM_PARTS-1:0] broken;
  logic                 play_flag;
  logic                 gameover_ctrl;
  logic [HEALTH_W-1:0]  health;
  logic [SCORE_W-1:0]   score;
  logic                 q_Init;
  logic                 q_Play;
  logic                 q_GameOver;

  modport master (
    input  timer_clk, BtnC, broken,
    output play_flag, gameover_ctrl, health, score, q_Init, q_Play, q_GameOver
  );

  modport slave (
    output timer_clk, BtnC, broken,
    input  play_flag, gameover_ctrl, health, score, q_Init, q_Play, q_GameOver
  );
endinterface

// File: rtl/nexys_starship_part_timer.sv
// Per-part broken-age tracker: grace period, periodic damage strobe and,
// with STARSHIP_SCORE_EN defined, a repair (falling broken) detector.
module nexys_starship_part_timer
  import nexys_starship_pkg::*;
#(
  parameter int GRACE_TICKS   = DEF_GRACE_TICKS,
  parameter int DAMAGE_PERIOD = DEF_DAMAGE_PERIOD
) (
  input  logic Clk,
  input  logic Reset_n,
  input  logic run,
  input  logic tick,
  input  logic broken,
  output logic strobe
`ifdef STARSHIP_SCORE_EN
  ,
  output logic fall
`endif
);
  localparam int AGE_W = $clog2(GRACE_TICKS + 1);
  localparam int PER_W = (DAMAGE_PERIOD > 1) ? $clog2(DAMAGE_PERIOD) : 1;
  localparam logic [AGE_W-1:0] AGE_SAT  = AGE_W'(GRACE_TICKS);
  localparam logic [AGE_W-1:0] AGE_LAST = AGE_W'(GRACE_TICKS - 1);
  localparam logic [PER_W-1:0] PER_LAST = PER_W'(DAMAGE_PERIOD - 1);

  logic [AGE_W-1:0] age_r;
  logic [PER_W-1:0] per_r;
  logic             aged_s;
  logic             step_s;

  // Once the grace age is reached it holds there; a phase counter paces repeats.
  assign aged_s = (age_r == AGE_SAT);
  assign step_s = run & tick & broken;
  assign strobe = step_s & (aged_s ? (per_r == PER_LAST) : (age_r == AGE_LAST));

  // Age and damage-phase counters, cleared whenever the part is not broken in play.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      age_r <= '0;
      per_r <= '0;
    end else if (!(run && broken)) begin
      age_r <= '0;
      per_r <= '0;
    end else if (tick) begin
      if (!aged_s) begin
        age_r <= age_r + AGE_W'(1);
      end else if (per_r == PER_LAST) begin
        per_r <= '0;
      end else begin
        per_r <= per_r + PER_W'(1);
      end
    end
  end

`ifdef STARSHIP_SCORE_EN
  logic broken_q_r;

  // Previous broken level for repair detection.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      broken_q_r <= 1'b0;
    end else begin
      broken_q_r <= broken;
    end
  end

  assign fall = broken_q_r & ~broken;
`endif

endmodule

// File: rtl/nexys_starship_game_ctrl.sv
// Nexys Starship game controller: INIT/PLAY/GAMEOVER flow, health drain from
// broken parts and, with STARSHIP_SCORE_EN defined, the repair score.
module nexys_starship_game_ctrl
  import nexys_starship_pkg::*;
#(
  parameter int NUM_PARTS     = 4,
  parameter int GRACE_TICKS   = DEF_GRACE_TICKS,
  parameter int DAMAGE_PERIOD = DEF_DAMAGE_PERIOD,
  parameter int MAX_HEALTH    = DEF_MAX_HEALTH,
  parameter int HEALTH_W      = 3,
  parameter int SCORE_W       = 8
) (
  input logic                          Clk,
  input logic                          Reset_n,
  nexys_starship_game_ctrl_if.master   bus
);
  localparam int CNT_W = $clog2(NUM_PARTS + 1);
  localparam int SUB_W = ((HEALTH_W > CNT_W) ? HEALTH_W : CNT_W) + 1;
  localparam logic [HEALTH_W-1:0] HEALTH_FULL = HEALTH_W'(MAX_HEALTH);

  state_t               state_r;
  logic                 play_flag_r;
  logic                 gameover_r;
  logic [HEALTH_W-1:0]  health_r;
  logic [HEALTH_W-1:0]  health_nxt_s;
  logic                 tsync1_r, tsync2_r, tprev_r, tick_s;
  logic                 btn_r, btn_rise_s;
  logic                 run_s;
  logic [NUM_PARTS-1:0] strobe_s;
  logic [CNT_W-1:0]     strobe_cnt_s;

  // timer_clk is asynchronous to Clk: two-flop synchronizer, then rise detect.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      tsync1_r <= 1'b0;
      tsync2_r <= 1'b0;
      tprev_r  <= 1'b0;
      btn_r    <= 1'b0;
    end else begin
      tsync1_r <= bus.timer_clk;
      tsync2_r <= tsync1_r;
      tprev_r  <= tsync2_r;
      btn_r    <= bus.BtnC;
    end
  end

  assign tick_s     = tsync2_r & ~tprev_r;
  assign btn_rise_s = bus.BtnC & ~btn_r;
  assign run_s      = (state_r == ST_PLAY);

`ifdef STARSHIP_SCORE_EN
  logic [NUM_PARTS-1:0] fall_s;
`endif

  for (genvar i = 0; i < NUM_PARTS; i++) begin : g_part
    nexys_starship_part_timer #(
      .GRACE_TICKS   (GRACE_TICKS),
      .DAMAGE_PERIOD (DAMAGE_PERIOD)
    ) u_timer (
      .Clk     (Clk),
      .Reset_n (Reset_n),
      .run     (run_s),
      .tick    (tick_s),
      .broken  (bus.broken[i]),
      .strobe  (strobe_s[i])
`ifdef STARSHIP_SCORE_EN
      ,
      .fall    (fall_s[i])
`endif
    );
  end

  // Damage count this cycle and saturating health update.
  always_comb begin
    strobe_cnt_s = '0;
    for (int i = 0; i < NUM_PARTS; i++) begin
      strobe_cnt_s = strobe_cnt_s + CNT_W'(strobe_s[i]);
    end
    if (SUB_W'(strobe_cnt_s) >= SUB_W'(health_r)) begin
      health_nxt_s = '0;
    end else begin
      health_nxt_s = health_r - HEALTH_W'(strobe_cnt_s);
    end
  end

  // Game FSM with registered play_flag, gameover_ctrl and health.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_r     <= ST_INIT;
      play_flag_r <= 1'b0;
      gameover_r  <= 1'b0;
      health_r    <= HEALTH_FULL;
    end else begin
      play_flag_r <= 1'b0;
      case (state_r)
        ST_INIT: begin
          health_r   <= HEALTH_FULL;
          gameover_r <= 1'b0;
          if (btn_rise_s) begin
            state_r     <= ST_PLAY;
            play_flag_r <= 1'b1;
          end
        end
        ST_PLAY: begin
          health_r <= health_nxt_s;
          if (health_r == '0) begin
            state_r    <= ST_GAMEOVER;
            gameover_r <= 1'b1;
          end
        end
        ST_GAMEOVER: begin
          gameover_r <= 1'b1;
          if (btn_rise_s) begin
            state_r    <= ST_INIT;
            gameover_r <= 1'b0;
            health_r   <= HEALTH_FULL;
          end
        end
        default: begin
          state_r    <= ST_INIT;
          gameover_r <= 1'b0;
          health_r   <= HEALTH_FULL;
        end
      endcase
    end
  end

`ifdef STARSHIP_SCORE_EN
  localparam int SUM_W = SCORE_W + 1;
  logic [CNT_W-1:0]   fall_cnt_s;
  logic [SUM_W-1:0]   score_sum_s;
  logic [SCORE_W-1:0] score_r;

  // Repairs this cycle added to the score, saturating at all-ones.
  always_comb begin
    fall_cnt_s = '0;
    for (int i = 0; i < NUM_PARTS; i++) begin
      fall_cnt_s = fall_cnt_s + CNT_W'(fall_s[i]);
    end
    score_sum_s = SUM_W'(score_r) + SUM_W'(fall_cnt_s);
  end

  // Score counts in PLAY, freezes in GAMEOVER, clears on the way back to INIT.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      score_r <= '0;
    end else begin
      case (state_r)
        ST_PLAY: begin
          if (score_sum_s[SCORE_W]) begin
            score_r <= {SCORE_W{1'b1}};
          end else begin
            score_r <= score_sum_s[SCORE_W-1:0];
          end
        end
        ST_GAMEOVER: begin
          if (btn_rise_s) begin
            score_r <= '0;
          end else begin
            score_r <= score_r;
          end
        end
        default: score_r <= '0;
      endcase
    end
  end

  assign bus.score = score_r;
`else
  assign bus.score = {SCORE_W{1'b0}};
`endif

  assign bus.play_flag     = play_flag_r;
  assign bus.gameover_ctrl = gameover_r;
  assign bus.health        = health_r;
  assign bus.q_Init        = state_r[0];
  assign bus.q_Play        = state_r[1];
  assign bus.q_GameOver    = state_r[2];

endmodule

// File: tb/tb_nexys_starship_game_ctrl.sv
// Bench for nexys_starship_game_ctrl: rule-level game model checked every
// cycle plus directed scenarios with literal expectations.
module tb_nexys_starship_game_ctrl;
  localparam int NP    = 4;
  localparam int G     = 8;
  localparam int P     = 4;
  localparam int MAXH  = 7;
`ifdef STARSHIP_SCORE_EN
  localparam int SCORE_ON = 1;
`else
  localparam int SCORE_ON = 0;
`endif

  logic Clk     = 1'b0;
  logic Reset_n = 1'b0;
  int   total   = 0;
  int   bad     = 0;

  nexys_starship_game_ctrl_if #(.NUM_PARTS(NP), .HEALTH_W(3), .SCORE_W(8)) bus ();

  nexys_starship_game_ctrl #(
    .NUM_PARTS(NP), .GRACE_TICKS(G), .DAMAGE_PERIOD(P),
    .MAX_HEALTH(MAXH), .HEALTH_W(3), .SCORE_W(8)
  ) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Game model: state 0=INIT 1=PLAY 2=GAMEOVER; ages count ticks spent broken.
  int   m_st, m_h, m_s, m_pf;
  int   m_age [NP];
  bit   m_tc [3];
  bit   m_btn_prev;
  logic [NP-1:0] m_brk_prev;

  task automatic model_reset();
    m_st = 0; m_h = MAXH; m_s = 0; m_pf = 0;
    for (int i = 0; i < NP; i++) m_age[i] = 0;
    for (int i = 0; i < 3; i++) m_tc[i] = 1'b0;
    m_btn_prev = 1'b0;
    m_brk_prev = '0;
  endtask

  task automatic model_step();
    bit tick, rise;
    int dmg, rep, old_h;
    tick = m_tc[1] & ~m_tc[2];
    rise = bus.BtnC & ~m_btn_prev;
    dmg = 0; rep = 0; m_pf = 0;
    for (int i = 0; i < NP; i++) begin
      if (m_st == 1 && bus.broken[i]) begin
        if (tick) begin
          m_age[i]++;
          if (m_age[i] == G || (m_age[i] > G && (m_age[i] - G) % P == 0)) dmg++;
        end
      end else begin
        m_age[i] = 0;
      end
      if (m_brk_prev[i] && !bus.broken[i]) rep++;
    end
    case (m_st)
      0: begin
        m_h = MAXH; m_s = 0;
        if (rise) begin m_st = 1; m_pf = 1; end
      end
      1: begin
        old_h = m_h;
        m_h = (dmg >= m_h) ? 0 : m_h - dmg;
        m_s = SCORE_ON ? ((m_s + rep > 255) ? 255 : m_s + rep) : 0;
        if (old_h == 0) m_st = 2;
      end
      default: begin
        if (rise) begin m_st = 0; m_h = MAXH; m_s = 0; end
      end
    endcase
    m_tc[2] = m_tc[1];
    m_tc[1] = m_tc[0];
    m_tc[0] = bus.timer_clk;
    m_btn_prev = bus.BtnC;
    m_brk_prev = bus.broken;
  endtask

  // Advance the model on every clock/reset event and compare all outputs.
  always @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) model_reset();
    else model_step();
    #1;
    chk("cyc_q_init",   32'(bus.q_Init),        32'(m_st == 0));
    chk("cyc_q_play",   32'(bus.q_Play),        32'(m_st == 1));
    chk("cyc_q_go",     32'(bus.q_GameOver),    32'(m_st == 2));
    chk("cyc_gameover", 32'(bus.gameover_ctrl), 32'(m_st == 2));
    chk("cyc_playflag", 32'(bus.play_flag),     32'(m_pf));
    chk("cyc_health",   32'(bus.health),        32'(m_h));
    chk("cyc_score",    32'(bus.score),         32'(m_s));
  end

  task automatic do_ticks(input int n);
    for (int k = 0; k < n; k++) begin
      bus.timer_clk = 1'b1;
      repeat (2) @(negedge Clk);
      bus.timer_clk = 1'b0;
      repeat (2) @(negedge Clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.timer_clk = 1'b0;
    bus.BtnC      = 1'b0;
    bus.broken    = '0;
    repeat (3) @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);
    chk("rst_q_init", 32'(bus.q_Init), 32'd1);
    chk("rst_health", 32'(bus.health), 32'd7);
    chk("rst_score",  32'(bus.score),  32'd0);
    chk("rst_pf",     32'(bus.play_flag), 32'd0);
    chk("rst_go",     32'(bus.gameover_ctrl), 32'd0);

    // start: one-cycle play_flag coincident with PLAY
    bus.BtnC = 1'b1;
    @(posedge Clk); #2;
    chk("start_pf",     32'(bus.play_flag), 32'd1);
    chk("start_q_play", 32'(bus.q_Play),    32'd1);
    chk("start_health", 32'(bus.health),    32'd7);
    @(posedge Clk); #2;
    chk("start_pf_drop", 32'(bus.play_flag), 32'd0);
    @(negedge Clk);
    bus.BtnC = 1'b0;

    // grace then periodic damage on part 0
    bus.broken = 4'b0001;
    do_ticks(7);
    chk("grace_7", 32'(bus.health), 32'd7);
    do_ticks(1);
    chk("grace_8", 32'(bus.health), 32'd6);
    do_ticks(8);
    chk("damage_16", 32'(bus.health), 32'd4);
    bus.broken = 4'b0000;
    @(negedge Clk);
    chk("fix0_score", 32'(bus.score), 32'(SCORE_ON));

    // repair before grace expires
    bus.broken = 4'b0010;
    do_ticks(5);
    bus.broken = 4'b0000;
    @(negedge Clk);
    chk("repair_score",  32'(bus.score),  32'(2 * SCORE_ON));
    chk("repair_health", 32'(bus.health), 32'd4);

    // drain to 2, then reset mid-game
    bus.broken = 4'b0100;
    do_ticks(12);
    bus.broken = 4'b0000;
    @(negedge Clk);
    chk("pre_rst_health", 32'(bus.health), 32'd2);
    chk("pre_rst_score",  32'(bus.score),  32'(3 * SCORE_ON));
    Reset_n = 1'b0;
    #2;
    chk("midrst_q_init", 32'(bus.q_Init), 32'd1);
    chk("midrst_health", 32'(bus.health), 32'd7);
    chk("midrst_score",  32'(bus.score),  32'd0);
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
    repeat (2) @(negedge Clk);
    chk("post_rst_idle", 32'(bus.q_Init), 32'd1);

    // second game; a BtnC edge in PLAY is ignored
    bus.BtnC = 1'b1;
    @(negedge Clk);
    bus.BtnC = 1'b0;
    @(negedge Clk);
    bus.BtnC = 1'b1;
    @(negedge Clk);
    bus.BtnC = 1'b0;
    @(negedge Clk);
    chk("btn_in_play", 32'(bus.q_Play), 32'd1);

    // all four parts broken together
    bus.broken = 4'b1111;
    do_ticks(8);
    chk("simul_8", 32'(bus.health), 32'd3);
    do_ticks(4);
    chk("simul_12",  32'(bus.health),        32'd0);
    chk("gameover",  32'(bus.gameover_ctrl), 32'd1);
    bus.broken = 4'b0000;
    repeat (2) @(negedge Clk);
    chk("go_score_frozen", 32'(bus.score),  32'd0);
    chk("go_health",       32'(bus.health), 32'd0);

    // restart
    bus.BtnC = 1'b1;
    @(posedge Clk); #2;
    chk("restart_q_init", 32'(bus.q_Init),        32'd1);
    chk("restart_go",     32'(bus.gameover_ctrl), 32'd0);
    chk("restart_health", 32'(bus.health),        32'd7);
    @(negedge Clk);
    bus.BtnC = 1'b0;
    repeat (2) @(negedge Clk);
    bus.BtnC = 1'b1;
    @(posedge Clk); #2;
    chk("restart_pf", 32'(bus.play_flag), 32'd1);
    @(negedge Clk);
    bus.BtnC = 1'b0;
    repeat (3) @(negedge Clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/nexys_starship_game_ctrl.md
# nexys_starship_game_ctrl

Top-level game controller for Nexys Starship, sitting downstream of the per-part repair state machines (top, bottom, left, right). It owns the INIT/PLAY/GAMEOVER flow, starts play with a `play_flag` pulse and stops it with `gameover_ctrl`. It watches every part's `*_broken` flag, drains ship health while parts stay broken, and scores completed repairs.

## Interface
Parameters:
- `NUM_PARTS`, 4: number of repairable parts; bit i of `broken` comes from repair SM i.
- `GRACE_TICKS`, 8: timer ticks a part may stay broken before the first damage.
- `DAMAGE_PERIOD`, 4: ticks between further damage while the part is still broken.
- `MAX_HEALTH`, 7: health loaded at INIT.
- `HEALTH_W`, 3: health width; must satisfy MAX_HEALTH < 2^HEALTH_W.
- `SCORE_W`, 8: score width.

Ports:
- `Clk`, in, 1: system clock.
- `Reset_n`, in, 1: one clock; reset is asynchronous and active-low.
- `timer_clk`, in, 1: slow game timer; sampled in the `Clk` domain, not used as a clock.
- `BtnC`, in, 1: debounced start/restart button level.
- `broken`, in, NUM_PARTS: `top_broken` and sibling flags from the repair SMs.
- `play_flag`, out, 1: one-cycle start pulse to the repair SMs.
- `gameover_ctrl`, out, 1: level, high while in GAMEOVER.
- `health`, out, HEALTH_W: remaining ship health.
- `score`, out, SCORE_W: repairs completed this game.
- `q_Init`, `q_Play`, `q_GameOver`, out, 1 each: one-hot state.

## Operation
- States: INIT, PLAY, GAMEOVER. Encoding is one-hot, and the output bits equal the state bits.
- **INIT**
  - Holds health = MAX_HEALTH, score = 0 and all part timers at 0.
  - A BtnC rising edge moves to PLAY and pulses `play_flag` for exactly one cycle, coincident with entry to PLAY.
- **PLAY**, per part i:
  - While `broken[i]`, its age counter increments on each tick.
  - The counter clears on any cycle where `broken[i]` is low.
  - A damage strobe fires on the tick where age reaches GRACE_TICKS, and again every DAMAGE_PERIOD ticks after that.
  - The age counter saturates internally; it never wraps.
- **Health**
  - Health is decremented by the number of damage strobes firing in that cycle, saturating at 0.
  - When health becomes 0, the next state is GAMEOVER.
- **Score**: increments by the number of `broken` falling edges in that cycle (repairs completed), saturating at 2^SCORE_W−1. Score counts only in PLAY.
- **GAMEOVER**
  - `gameover_ctrl` = 1. Health and score are frozen.
  - A BtnC rising edge returns to INIT and `gameover_ctrl` drops.
- BtnC edges in PLAY are ignored.
- Unreachable state encodings recover to INIT.

## Timing
- Reset values:
  - State INIT (`q_Init` = 1, others 0).
  - `play_flag` 0, `gameover_ctrl` 0.
  - `health` = MAX_HEALTH, `score` 0.
  - Sync, edge and age registers 0.
- **Tick**: `timer_clk` passes through a 2-flop synchronizer plus an edge register. The tick is a one-cycle pulse on the third `Clk` edge after `timer_clk` rises.
- **BtnC**: single edge register, so a one-cycle latency from the sampled rise to the state change.
- Damage and repair updates appear on `health` and `score` one cycle after the tick/edge cycle.
- GAMEOVER is entered one cycle after `health` registers 0.
- Simultaneous events:
  - Repair and damage in the same cycle: both apply.
  - A damage strobe and a falling `broken` on the same tick: the falling edge wins, so no damage and the score increments.
  - Damage greater than remaining health: health goes to 0, with no underflow.
- `Reset_n` asserted mid-game returns everything to reset values immediately. No `play_flag` is produced until a fresh BtnC edge.

## Configuration
- `STARSHIP_SCORE_EN` defined: falling-edge detectors and the score counter are built as above.
- `STARSHIP_SCORE_EN` undefined: no score logic is built and `score` is tied to 0. State flow and health are unchanged.

## Structure
- Shared package `nexys_starship_pkg`:
  - State localparams INIT/PLAY/GAMEOVER.
  - Default MAX_HEALTH, GRACE_TICKS and DAMAGE_PERIOD constants.
  - Part index constants (TOP = 0, BOTTOM = 1, LEFT = 2, RIGHT = 3).
- Sub-module `nexys_starship_part_timer`:
  - Contents: one age counter, the damage strobe and the optional falling-edge detect.
  - Instantiated NUM_PARTS times via generate.
- Top level keeps the FSM, the tick/button synchronizers, the popcount of strobes and the health/score registers.

## Test plan
- **Start**: reset, BtnC rise → `play_flag` high for exactly one cycle, `q_Play` = 1, `health` = 7, `score` = 0.
- **Grace and damage**: in PLAY, hold `broken[0]` = 1 for 16 ticks → `health` drops to 6 after tick 8, then 5, 4 and 3 after ticks 12, 16 and 20… Check exactly 3 decrements by tick 16.
- **Repair**: `broken[1]` high 5 ticks then low → `score` = 1, no health loss, age counter cleared.
- **Simultaneous**: `broken[3:0]` = 4'hF for 8 ticks → health 7 → 3 in a single update; continue → saturates at 0, then `gameover_ctrl` = 1 one cycle later.
- **Restart**: in GAMEOVER, BtnC rise → INIT, `gameover_ctrl` = 0, `health` = 7, `score` = 0; a second BtnC rise → `play_flag` pulse.
- **Reset mid-game**: `Reset_n` low during PLAY with `health` = 2 → immediately `q_Init` = 1, `health` = 7, `score` = 0.
